// File: rtl/store_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor_pkg
// Description : Shared state encoding and default match/timeout settings for
//               the store monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package store_monitor_pkg;

  // The encoding is visible on the state output, so keep the values fixed.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TOUT = 3'd4
  } state_t;

  localparam logic [31:0] DEF_EXPECT_ADDR    = 32'd100;
  localparam logic [31:0] DEF_EXPECT_DATA    = 32'd7;
  localparam logic [31:0] DEF_ALLOW_ADDR     = 32'd96;
  localparam int          DEF_TIMEOUT_CYCLES = 1000;

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_timer
// Description : 20-bit idle-cycle counter.
//               expired is raised on the cycle whose edge will bring the
//               count to TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The count reaches TIMEOUT_CYCLES-1 on the edge where it is incremented
  // away from TIMEOUT_CYCLES-2.
  localparam logic [19:0] LAST_STEP = 20'(TIMEOUT_CYCLES - 2);

  logic [19:0] count;

  // Count enabled cycles; clear or reset takes precedence.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= 20'd0;
    end else if (enable) begin
      count <= count + 20'd1;
    end
  end

  assign expired = enable && (count == LAST_STEP);

endmodule
`default_nettype wire

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor
// Description : Watches processor data-memory stores after being armed and
//               decides PASS (expected store seen), FAIL (unexpected store)
//               or TOUT (no decisive store within the cycle budget).
// Revision    : 1.0 - initial release
// ============================================================================
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [31:0] EXPECT_ADDR    = DEF_EXPECT_ADDR,
  parameter logic [31:0] EXPECT_DATA    = DEF_EXPECT_DATA,
  parameter logic [31:0] ALLOW_ADDR     = DEF_ALLOW_ADDR,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [2:0]  state,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [7:0]  store_count,
  output logic [31:0] last_addr,
  output logic [31:0] last_data
);

  state_t cur_state;
  state_t nxt_state;
  logic   run_store;
  logic   expired;

  // Only stores made while running are counted or judged.
  assign run_store = MemWrite && (cur_state == ST_RUN);

  // The timer sits at zero outside RUN and advances only on store-free cycles.
  cycle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_cycle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (cur_state == ST_IDLE),
    .enable  ((cur_state == ST_RUN) && !MemWrite),
    .expired (expired)
  );

  // Next-state decision; a store outranks a coincident timeout.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE: begin
        if (arm) nxt_state = ST_RUN;
      end
      ST_RUN: begin
        if (MemWrite) begin
          if ((DataAdr == EXPECT_ADDR) && (WriteData == EXPECT_DATA)) begin
            nxt_state = ST_PASS;
          end else if (DataAdr == ALLOW_ADDR) begin
            nxt_state = ST_RUN;
          end else begin
            nxt_state = ST_FAIL;
          end
        end else if (expired) begin
          nxt_state = ST_TOUT;
        end
      end
      default: nxt_state = cur_state;
    endcase
  end

  // State and flag registers; flags are decoded from the next state so they
  // line up with the state output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= ST_IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      done      <= (nxt_state == ST_PASS) || (nxt_state == ST_FAIL) ||
                   (nxt_state == ST_TOUT);
      pass      <= (nxt_state == ST_PASS);
      fail      <= (nxt_state == ST_FAIL) || (nxt_state == ST_TOUT);
    end
  end

  // Store history: saturating count and most recent address/data in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      store_count <= 8'd0;
      last_addr   <= 32'd0;
      last_data   <= 32'd0;
    end else if (run_store) begin
      if (store_count != 8'hFF) store_count <= store_count + 8'd1;
      last_addr <= DataAdr;
      last_data <= WriteData;
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter EXPECT_ADDR, default 32'd100: address of the success store.
REQ-002 Parameter EXPECT_DATA, default 32'd7: data value of the success store.
REQ-003 Parameter ALLOW_ADDR, default 32'd96: the only address that may be written before success without failing.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000: RUN cycles allowed before timeout; legal range 2 to 2^20-1.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 reset  input  1  one clock; reset is synchronous and active-low.
REQ-007 arm  input  1  level; starts monitoring when the block is in IDLE.
REQ-008 MemWrite  input  1  processor data-memory write strobe.
REQ-009 DataAdr  input  32  processor data-memory byte address.
REQ-010 WriteData  input  32  processor data-memory store data.
REQ-011 state  output  3  current FSM state encoding.
REQ-012 done  output  1  high in PASS, FAIL or TOUT.
REQ-013 pass  output  1  high only in PASS.
REQ-014 fail  output  1  high in FAIL or TOUT.
REQ-015 store_count  output  8  number of stores accepted in RUN, saturating.
REQ-016 last_addr / last_data  output  32 each  address and data of the most recent store accepted in RUN.

Function
REQ-017 FSM states SHALL be IDLE, RUN, PASS, FAIL and TOUT.
REQ-018 IDLE->RUN SHALL occur on the first edge with arm=1; stores seen while in IDLE SHALL be ignored.
REQ-019 In RUN, a store (MemWrite=1) with DataAdr==EXPECT_ADDR and WriteData==EXPECT_DATA SHALL move the FSM to PASS.
REQ-020 In RUN, a store with DataAdr==ALLOW_ADDR SHALL keep the FSM in RUN.
REQ-021 In RUN, any other store SHALL move the FSM to FAIL, including EXPECT_ADDR with wrong data.
REQ-022 Every store in RUN SHALL increment store_count, saturating at 255, and load last_addr/last_data, including the store that ends RUN.
REQ-023 The RUN cycle counter SHALL clear on IDLE->RUN and increment on each cycle without a store.
REQ-024 The FSM SHALL move RUN->TOUT on the edge where the counter reaches TIMEOUT_CYCLES-1 and no store occurs.
REQ-025 When a store and timeout expiry occur on the same edge, the store outcome (PASS or FAIL) SHALL take priority.
REQ-026 PASS, FAIL and TOUT SHALL be sticky until reset; arm and stores SHALL then be ignored.
REQ-027 Every output SHALL be a registered value and SHALL reflect a store one cycle after the sampling edge.
REQ-028 Address and data comparisons SHALL be full 32-bit equality with no byte masking.

Reset
REQ-029 reset=0 sampled at a rising edge SHALL force state=IDLE, done=0, pass=0, fail=0, store_count=0, last_addr=0, last_data=0 and cycle counter=0.
REQ-030 Reset asserted mid-RUN or in a terminal state SHALL discard all history; arm is honoured starting on the first edge after reset returns to 1.

Structure
REQ-031 Package store_monitor_pkg SHALL hold the state enum and the default values of EXPECT_ADDR, EXPECT_DATA, ALLOW_ADDR and TIMEOUT_CYCLES.
REQ-032 The 20-bit timeout counter SHALL be a sub-module, cycle_timer, with ports clk, reset, clear, enable and expired.
REQ-033 The block SHALL be synthesizable, so the same pass/fail decision drives board LEDs on the FPGA build.

Verification
REQ-034 Reset for 2 cycles, arm=1, store (96,5), then store (100,7): state RUN->PASS, pass=1, store_count=2, last_addr=100.
REQ-035 arm=1, store (100,6): FAIL on the next cycle, fail=1, pass=0, last_data=6.
REQ-036 arm=1 with no stores, TIMEOUT_CYCLES=16: TOUT after exactly 15 RUN cycles, done=1, fail=1.
REQ-037 TIMEOUT_CYCLES=16, store (100,7) on the expiry edge: PASS, not TOUT; repeat with store (104,0): FAIL.
REQ-038 Store (100,7) while in IDLE: no change, store_count=0; 300 stores to 96 in RUN: store_count holds at 255, state stays RUN.
REQ-039 In PASS, drive reset=0 for one cycle: all outputs return to their reset values; arm then restarts RUN.
